// File: rtl/factorial_pkg.sv
// Shared definitions for the iterative factorial engine: control-unit state codes
// used by both the control unit and the datapath.
package factorial_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_TEST = 3'd1;
  localparam logic [STATE_W-1:0] ST_MUL  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DEC  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/fact_mul.sv
// Single-cycle combinational multiplier for the factorial datapath.
// With FACTORIAL_OVF_EN defined, it also flags any product bits above OUT_W.
module fact_mul #(
  parameter int OUT_W = 32,
  parameter int SIZE  = 8
) (
  input  logic [OUT_W-1:0] a,
  input  logic [SIZE-1:0]  b,
`ifdef FACTORIAL_OVF_EN
  output logic             ovf,
`endif
  output logic [OUT_W-1:0] prod
);

`ifdef FACTORIAL_OVF_EN
  logic [OUT_W+SIZE-1:0] full;

  assign full = (OUT_W+SIZE)'(a) * (OUT_W+SIZE)'(b);
  assign prod = full[OUT_W-1:0];
  assign ovf  = |full[OUT_W+SIZE-1:OUT_W];
`else
  // Without overflow detection only the low half is ever needed; it wraps mod 2^OUT_W.
  assign prod = a * OUT_W'(b);
`endif

endmodule

// File: rtl/factorial_dp.sv
// Datapath of the iterative factorial engine: counter, accumulator and sticky overflow,
// stepped by the control unit's state. Optional overflow detect: FACTORIAL_OVF_EN.
module factorial_dp
  import factorial_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [STATE_W-1:0] curr_state,
  input  logic [SIZE-1:0]    n,
  output logic               proceed,
  output logic [OUT_W-1:0]   result,
  output logic               overflow
);

  logic [SIZE-1:0]  cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] prod;

`ifdef FACTORIAL_OVF_EN
  logic ovf;
  logic prod_ovf;

  fact_mul #(.OUT_W(OUT_W), .SIZE(SIZE)) u_mul (
    .a    (acc),
    .b    (cnt),
    .ovf  (prod_ovf),
    .prod (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (init) begin
      ovf <= 1'b0;
    end else if (curr_state == ST_MUL) begin
      ovf <= ovf | prod_ovf;
    end
  end

  assign overflow = ovf;
`else
  fact_mul #(.OUT_W(OUT_W), .SIZE(SIZE)) u_mul (
    .a    (acc),
    .b    (cnt),
    .prod (prod)
  );

  assign overflow = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; blocking here would let acc see a cnt updated in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (init) begin
      cnt <= n;
      acc <= OUT_W'(1);
    end else begin
      case (curr_state)
        ST_MUL: acc <= prod;
        ST_DEC: if (cnt != '0) cnt <= cnt - 1'b1;  // saturate at zero, never wrap
        default: ;  // IDLE, TEST, DONE and unused codes hold everything
      endcase
    end
  end

  // Combinational so TEST sees the count left by the preceding DEC or init.
  assign proceed = (cnt > SIZE'(1));
  assign result  = acc;

endmodule

// File: tb/tb_factorial_dp.sv
// Directed bench for factorial_dp; a behavioural control unit sequence is driven
// from tasks and every result is compared against hand-computed constants.
module tb_factorial_dp;
  import factorial_pkg::*;

  localparam int SIZE  = 8;
  localparam int OUT_W = 32;

`ifdef FACTORIAL_OVF_EN
  localparam logic OVF13 = 1'b1;
`else
  localparam logic OVF13 = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               init;
  logic [STATE_W-1:0] curr_state;
  logic [SIZE-1:0]    n;
  logic               proceed;
  logic [OUT_W-1:0]   result;
  logic               overflow;

  int checks   = 0;
  int failures = 0;

  factorial_dp #(.SIZE(SIZE), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .curr_state (curr_state),
    .n          (n),
    .proceed    (proceed),
    .result     (result),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold one control-unit state for a full clock cycle.
  task automatic step(input logic [STATE_W-1:0] st);
    curr_state = st;
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [SIZE-1:0] nv, input logic [STATE_W-1:0] st);
    n          = nv;
    init       = 1'b1;
    curr_state = st;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  // TEST -> (MUL -> DEC -> TEST)* -> DONE, steered by proceed like the real control unit.
  task automatic run_loop(input string tag, output int iters);
    bit done;
    iters = 0;
    done  = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      step(ST_TEST);
      if (proceed) begin
        step(ST_MUL);
        step(ST_DEC);
        iters++;
      end else begin
        step(ST_DONE);
        done = 1'b1;
      end
    end
    if (!done) check({tag, "_loop_bound"}, 64'd1, 64'd0);
  endtask

  task automatic run_fact(input string tag, input logic [SIZE-1:0] nv,
                          input logic [OUT_W-1:0] exp_res, input logic exp_ovf,
                          input int exp_iters);
    int iters;
    do_init(nv, ST_IDLE);
    check({tag, "_proceed_init"}, 64'(proceed), 64'(nv > 1));
    check({tag, "_ovf_init"}, 64'(overflow), 64'd0);
    run_loop(tag, iters);
    check({tag, "_iters"}, 64'(iters), 64'(exp_iters));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, "_proceed_done"}, 64'(proceed), 64'd0);
    repeat (3) step(ST_DONE);
    check({tag, "_result_stable"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    int iters;
    rst        = 1'b1;
    init       = 1'b0;
    curr_state = ST_IDLE;
    n          = '0;
    #12;
    check("reset_result", 64'(result), 64'd0);
    check("reset_proceed", 64'(proceed), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_fact("n5", 8'd5, 32'd120, 1'b0, 4);
    run_fact("n0", 8'd0, 32'd1, 1'b0, 0);

    // DEC on a zero count must saturate; a following MUL then yields 1*0.
    step(ST_DEC);
    check("dec_sat_proceed", 64'(proceed), 64'd0);
    step(ST_MUL);
    check("dec_sat_mul", 64'(result), 64'd0);

    run_fact("n1", 8'd1, 32'd1, 1'b0, 0);
    run_fact("n12", 8'd12, 32'd479001600, 1'b0, 11);
    run_fact("n13", 8'd13, 32'd1932053504, OVF13, 12);
    run_fact("n3", 8'd3, 32'd6, 1'b0, 2);

    // init beats a simultaneous MUL (acc would otherwise become 6*1).
    do_init(8'd7, ST_MUL);
    check("init_wins_result", 64'(result), 64'd1);
    check("init_wins_proceed", 64'(proceed), 64'd1);
    step(ST_TEST);
    step(ST_MUL);
    step(ST_DEC);
    check("n7_first_mul", 64'(result), 64'd7);
    step(3'd6);
    step(3'd5);
    step(3'd7);
    step(3'd6);
    step(3'd6);
    check("undef_hold_result", 64'(result), 64'd7);
    check("undef_hold_proceed", 64'(proceed), 64'd1);
    run_loop("n7", iters);
    check("n7_iters", 64'(iters), 64'd5);
    check("n7_result", 64'(result), 64'd5040);

    // Asynchronous reset asserted mid-cycle while the control unit sits in DEC.
    do_init(8'd5, ST_IDLE);
    step(ST_TEST);
    step(ST_MUL);
    curr_state = ST_DEC;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_result", 64'(result), 64'd0);
    check("rst_async_proceed", 64'(proceed), 64'd0);
    check("rst_async_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    curr_state = ST_IDLE;
    @(posedge clk);
    #1;
    run_fact("n4", 8'd4, 32'd24, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
